dbg_regfile_ctrl: RTL and testbench

- Debug halt controller and register-file port arbiter for the 3-stage core.
- Stops the pipeline on host request: holds PC, bubbles ID, drains EX.
- While halted, gives the register-file read/write ports to a debug host (e.g. UART bridge) instead of decode/execute.
- Releases ports back and resumes the core on request.

---
 rtl/dbg_regfile_ctrl_if.sv | 29 ++
 rtl/dbg_regfile_ctrl.sv | 145 ++++++++++++++
 tb/tb_dbg_regfile_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dbg_regfile_ctrl_if.sv
// Debug host bus: halt/resume control plus a single-outstanding register access
// channel between a debug bridge (master) and the halt controller (slave).
interface dbg_regfile_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              dbg_halt_req;
    logic              dbg_resume_req;
    logic              dbg_halted;
    logic              dbg_req_valid;
    logic              dbg_req_ready;
    logic              dbg_req_we;
    logic [ADDR_W-1:0] dbg_req_addr;
    logic [DATA_W-1:0] dbg_req_wdata;
    logic              dbg_rsp_valid;
    logic [DATA_W-1:0] dbg_rsp_rdata;

    modport master (
        output dbg_halt_req, dbg_resume_req, dbg_req_valid, dbg_req_we,
               dbg_req_addr, dbg_req_wdata,
        input  dbg_halted, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata
    );

    modport slave (
        input  dbg_halt_req, dbg_resume_req, dbg_req_valid, dbg_req_we,
               dbg_req_addr, dbg_req_wdata,
        output dbg_halted, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata
    );
endinterface

// File: rtl/dbg_regfile_ctrl.sv
// Debug halt controller: drains the 3-stage pipeline on host request, then hands
// the register-file ports to the debug host until a resume is requested.
module dbg_regfile_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dbg_regfile_ctrl_if.slave dbg,
    input  logic [ADDR_W-1:0] id_rs1_addr,
    input  logic [ADDR_W-1:0] id_rs2_addr,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    input  logic              ex_rd_wen,
    input  logic [DATA_W-1:0] ex_rd_data,
    input  logic              ex_jump_en,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_wen,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              hold_pc,
    output logic              flush_id
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nxt_s;
    logic              accept_s;
    logic              core_owns_s;
    logic              halted_r;
    logic              ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              hold_r;

    assign accept_s    = ready_r & dbg.dbg_req_valid;
    assign core_owns_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);

    // Next-state and drain-counter logic; a pending access always beats resume.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (dbg.dbg_halt_req) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = DRAIN_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (ex_jump_en) begin
                    cnt_nxt_s = DRAIN_LOAD;
                end else if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_HALTED;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_HALTED: begin
                if (accept_s) begin
                    state_nxt_s = ST_RESP;
                end else if (dbg.dbg_resume_req) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_HALTED;
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and status outputs, registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            cnt_r       <= 4'd0;
            halted_r    <= 1'b0;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            hold_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            halted_r    <= (state_nxt_s == ST_HALTED) || (state_nxt_s == ST_RESP);
            ready_r     <= (state_nxt_s == ST_HALTED);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            hold_r      <= (state_nxt_s != ST_RUN);
        end
    end

    // Response data: captured on accept, held until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            rsp_rdata_r <= dbg.dbg_req_we ? {DATA_W{1'b0}} : rf_rdata1;
        end else begin
            rsp_rdata_r <= rsp_rdata_r;
        end
    end

    // Register-file port mux; x0 writes from the host are suppressed.
    always_comb begin
        rf_raddr1 = id_rs1_addr;
        rf_raddr2 = id_rs2_addr;
        rf_waddr  = ex_rd_addr;
        rf_wen    = ex_rd_wen;
        rf_wdata  = ex_rd_data;
        if (core_owns_s) begin
            rf_raddr1 = id_rs1_addr;
        end else begin
            rf_raddr1 = dbg.dbg_req_addr;
            rf_raddr2 = {ADDR_W{1'b0}};
            rf_waddr  = dbg.dbg_req_addr;
            rf_wdata  = dbg.dbg_req_wdata;
            rf_wen    = accept_s & dbg.dbg_req_we &
                        (dbg.dbg_req_addr != {ADDR_W{1'b0}});
        end
    end

    assign dbg.dbg_halted    = halted_r;
    assign dbg.dbg_req_ready = ready_r;
    assign dbg.dbg_rsp_valid = rsp_valid_r;
    assign dbg.dbg_rsp_rdata = rsp_rdata_r;
    assign hold_pc           = hold_r;
    assign flush_id          = hold_r;
endmodule

// File: tb/tb_dbg_regfile_ctrl.sv
// Directed bench for dbg_regfile_ctrl with a small behavioural register file.
module tb_dbg_regfile_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          ex_rd_wen, ex_jump_en;
    logic [DW-1:0] ex_rd_data;
    logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [DW-1:0] rf_rdata1, rf_wdata;
    logic          rf_wen, hold_pc, flush_id;

    int checks   = 0;
    int failures = 0;
    int wen_cnt  = 0;
    int wen_base;

    logic [DW-1:0] rf_mem [32];

    dbg_regfile_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_bus ();

    dbg_regfile_ctrl #(.DRAIN_CYCLES(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dbg         (dbg_bus.slave),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .ex_rd_addr  (ex_rd_addr),
        .ex_rd_wen   (ex_rd_wen),
        .ex_rd_data  (ex_rd_data),
        .ex_jump_en  (ex_jump_en),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_waddr    (rf_waddr),
        .rf_wen      (rf_wen),
        .rf_wdata    (rf_wdata),
        .hold_pc     (hold_pc),
        .flush_id    (flush_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf_mem[rf_raddr1];

    always @(posedge clk) begin
        if (rf_wen) begin
            rf_mem[rf_waddr] <= rf_wdata;
            wen_cnt <= wen_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One host access from HALTED: accept cycle, then the response cycle.
    task automatic dbg_access(input string tag, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
        @(negedge clk);
        chk({tag, "_ready_pre"}, 32'(dbg_bus.dbg_req_ready), 32'd1);
        dbg_bus.dbg_req_valid = 1'b1;
        dbg_bus.dbg_req_we    = we;
        dbg_bus.dbg_req_addr  = addr;
        dbg_bus.dbg_req_wdata = wdata;
        #1;
        chk({tag, "_rf_wen"}, 32'(rf_wen), 32'((we && addr != 5'd0) ? 1 : 0));
        chk({tag, "_rf_addr"}, 32'(we ? rf_waddr : rf_raddr1), 32'(addr));
        @(negedge clk);
        dbg_bus.dbg_req_valid = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(dbg_bus.dbg_rsp_valid), 32'd1);
        chk({tag, "_ready_resp"}, 32'(dbg_bus.dbg_req_ready), 32'd0);
        chk({tag, "_rdata"}, dbg_bus.dbg_rsp_rdata, exp_rdata);
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        ex_rd_wen = 1'b0; ex_rd_data = 32'd0; ex_jump_en = 1'b0;
        dbg_bus.dbg_halt_req = 1'b0; dbg_bus.dbg_resume_req = 1'b0;
        dbg_bus.dbg_req_valid = 1'b0; dbg_bus.dbg_req_we = 1'b0;
        dbg_bus.dbg_req_addr = 5'd0; dbg_bus.dbg_req_wdata = 32'd0;

        @(negedge clk);
        chk("rst_halted", 32'(dbg_bus.dbg_halted), 32'd0);
        chk("rst_ready", 32'(dbg_bus.dbg_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 32'd0);
        chk("rst_rdata", dbg_bus.dbg_rsp_rdata, 32'd0);
        chk("rst_hold", 32'({hold_pc, flush_id}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RUN: core drives rf ports; resume alone is ignored
        @(negedge clk);
        id_rs1_addr = 5'd3; id_rs2_addr = 5'd4; ex_rd_addr = 5'd9;
        ex_rd_wen = 1'b1; ex_rd_data = 32'h55;
        dbg_bus.dbg_resume_req = 1'b1;
        #1;
        chk("run_raddr", 32'({rf_raddr1, rf_raddr2}), 32'({5'd3, 5'd4}));
        chk("run_wr", 32'({rf_wen, rf_waddr}), 32'({1'b1, 5'd9}));
        chk("run_wdata", rf_wdata, 32'h55);
        @(negedge clk);
        ex_rd_wen = 1'b0; dbg_bus.dbg_resume_req = 1'b0;
        chk("run_resume_ignored", 32'(hold_pc), 32'd0);

        // Halt with no jumps: cycle 0 request, hold from cycle 1, halted at cycle 3
        dbg_bus.dbg_halt_req = 1'b1;
        @(negedge clk);
        chk("drain1_hold", 32'({hold_pc, flush_id}), 32'd3);
        chk("drain1_halted", 32'(dbg_bus.dbg_halted), 32'd0);
        ex_rd_addr = 5'd5; ex_rd_data = 32'h1234; ex_rd_wen = 1'b1;
        #1;
        chk("drain1_ex_wen", 32'({rf_wen, rf_waddr}), 32'({1'b1, 5'd5}));
        @(negedge clk);
        ex_rd_wen = 1'b0;
        chk("drain2_halted", 32'(dbg_bus.dbg_halted), 32'd0);
        @(negedge clk);
        dbg_bus.dbg_halt_req = 1'b0;
        chk("halt3_halted", 32'(dbg_bus.dbg_halted), 32'd1);
        chk("halt3_ready", 32'(dbg_bus.dbg_req_ready), 32'd1);
        chk("halt3_raddr2", 32'(rf_raddr2), 32'd0);

        // Host accesses
        wen_base = wen_cnt;
        dbg_access("wr_x7", 1'b1, 5'd7, 32'hDEADBEEF, 32'd0);
        chk("wr_x7_wen_pulses", 32'(wen_cnt - wen_base), 32'd1);
        dbg_access("rd_x7", 1'b0, 5'd7, 32'd0, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_x7_rsp_drop", 32'(dbg_bus.dbg_rsp_valid), 32'd0);
        chk("rd_x7_rdata_hold", dbg_bus.dbg_rsp_rdata, 32'hDEADBEEF);
        dbg_access("rd_x5", 1'b0, 5'd5, 32'd0, 32'h1234);
        wen_base = wen_cnt;
        dbg_access("wr_x0", 1'b1, 5'd0, 32'hFFFFFFFF, 32'd0);
        chk("wr_x0_no_wen", 32'(wen_cnt - wen_base), 32'd0);
        dbg_access("rd_x0", 1'b0, 5'd0, 32'd0, 32'd0);

        // Resume together with a read: read first, then back to RUN
        dbg_bus.dbg_resume_req = 1'b1;
        dbg_access("rd_resume", 1'b0, 5'd7, 32'd0, 32'hDEADBEEF);
        @(negedge clk);
        chk("resume_halted_again", 32'({dbg_bus.dbg_halted, hold_pc}), 32'd3);
        @(negedge clk);
        dbg_bus.dbg_resume_req = 1'b0;
        chk("resume_run_hold", 32'({hold_pc, flush_id}), 32'd0);
        chk("resume_run_halted", 32'(dbg_bus.dbg_halted), 32'd0);
        id_rs1_addr = 5'd12; id_rs2_addr = 5'd13;
        #1;
        chk("resume_core_addr", 32'({rf_raddr1, rf_raddr2}), 32'({5'd12, 5'd13}));

        // Jump in drain cycle 1 delays halt by one cycle; dropping halt_req does not abort
        @(negedge clk);
        dbg_bus.dbg_halt_req = 1'b1;
        @(negedge clk);
        dbg_bus.dbg_halt_req = 1'b0;
        ex_jump_en = 1'b1;
        @(negedge clk);
        ex_jump_en = 1'b0;
        chk("jmp_c2_halted", 32'(dbg_bus.dbg_halted), 32'd0);
        @(negedge clk);
        chk("jmp_c3_halted", 32'({dbg_bus.dbg_halted, hold_pc}), 32'd1);
        @(negedge clk);
        chk("jmp_c4_halted", 32'(dbg_bus.dbg_halted), 32'd1);

        // Reset during RESP drops the access
        dbg_access("rd_pre_rst", 1'b0, 5'd5, 32'd0, 32'h1234);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(dbg_bus.dbg_rsp_valid), 32'd0);
        chk("rst_resp_halted", 32'({dbg_bus.dbg_halted, dbg_bus.dbg_req_ready, hold_pc}), 32'd0);
        chk("rst_resp_rdata", dbg_bus.dbg_rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Halt and resume together in RUN: halt wins
        @(negedge clk);
        dbg_bus.dbg_halt_req = 1'b1; dbg_bus.dbg_resume_req = 1'b1;
        @(negedge clk);
        dbg_bus.dbg_halt_req = 1'b0; dbg_bus.dbg_resume_req = 1'b0;
        chk("halt_resume_drain", 32'({hold_pc, dbg_bus.dbg_halted}), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
